ahblite_block_ram_ctrl: RTL and testbench
=========================================

// Module: ahblite_block_ram_ctrl
//
// PURPOSE
// AHB-Lite slave controller for a single-clock, simple-dual-port block RAM
// (one synchronous read port, one byte-enabled write port).
// Reads are zero-wait: the address phase drives the read port directly.
// Writes are sequenced: address-phase control is registered and committed
// in the data phase, when HWDATA is valid.
// Read-after-write to the same word in back-to-back transfers is resolved by
// byte-lane forwarding. Sits between the AHB-Lite matrix and the RAM macro,
// alongside the boot ROM slave.
//
// PARAMETERS
// ADDR_WIDTH  13  word-address width; RAM holds 2^ADDR_WIDTH 32-bit words
//
// PORTS
// HCLK         in   1           system clock, all state on rising edge
// HRESETn      in   1           async active-low reset
// HSEL         in   1           slave select (address phase)
// HADDR        in   32          byte address (address phase)
// HTRANS       in   2           transfer type; bit1=1 means NONSEQ/SEQ
// HSIZE        in   3           transfer size: 0=byte, 1=half, 2=word
// HPROT        in   4           protection; ignored
// HWRITE       in   1           1=write, 0=read (address phase)
// HWDATA       in   32          write data (data phase)
// HREADY       in   1           bus ready; address phase accepted when 1
// HREADYOUT    out  1           slave ready; constant 1
// HRDATA       out  32          read data (data phase)
// HRESP        out  2           response; constant 2'b00 (OKAY)
// BRAM_RDADDR  out  ADDR_WIDTH  read-port word address
// BRAM_WRADDR  out  ADDR_WIDTH  write-port word address
// BRAM_WE      out  4           per-byte write enables, bit n = HWDATA[8n+7:8n]
// BRAM_WDATA   out  32          write-port data
// BRAM_RDATA   in   32          read-port data, 1-cycle latency, read-first
//
// BEHAVIOUR
// - Accept: acc = HSEL & HTRANS[1] & HREADY. IDLE/BUSY or HREADY=0 -> no capture.
// - Word address: HADDR[ADDR_WIDTH+1:2]. Upper bits are ignored, so the RAM
//   aliases across its region.
// - Byte-enable decode from HSIZE/HADDR[1:0]:
//     size 0 -> 4'b0001 << HADDR[1:0]
//     size 1 -> HADDR[1] ? 4'b1100 : 4'b0011
//     size >= 2 -> 4'b1111
//   Misaligned low bits are ignored.
// - Data-phase state, one register set, updated every HCLK:
//     IDLE: no transfer owned
//     WR:   write data phase
//     RD:   read data phase
//   Next state = acc ? (HWRITE ? WR : RD) : IDLE, evaluated every cycle.
//   HREADYOUT=1 means each data phase lasts exactly 1 cycle.
// - Write, address phase: register wr_addr_q <= word address and
//   wr_be_q <= decoded enables.
// - Write, data phase (state WR): BRAM_WE = wr_be_q, BRAM_WRADDR = wr_addr_q,
//   BRAM_WDATA = HWDATA. Outside WR, BRAM_WE = 4'b0000.
//   BRAM_WRADDR and BRAM_WDATA are don't-care when BRAM_WE = 0.
// - Read: BRAM_RDADDR = HADDR word address combinationally, every cycle.
//   HRDATA is valid in the following (RD) cycle.
// - Hazard: in state WR, if acc & !HWRITE & word address == wr_addr_q, register
//   fwd_en=1, fwd_be=wr_be_q, fwd_data=HWDATA. Otherwise fwd_en=0.
// - In state RD, per byte n: HRDATA byte n = (fwd_en & fwd_be[n]) ?
//   fwd_data byte n : BRAM_RDATA byte n.
// - HRDATA in IDLE/WR: BRAM_RDATA pass-through; bus ignores it.
// - Write followed by write to the same word needs no special handling;
//   writes commit in order.
// - Reset values: state=IDLE, wr_addr_q=0, wr_be_q=0, fwd_en=0, fwd_be=0,
//   fwd_data=0, BRAM_WE=0, HREADYOUT=1, HRESP=0.
// - Reset asserted mid-transfer: a pending write is dropped (WE forced to 0
//   immediately) and forwarding is cleared.
//
// TESTING
// 1. Write 32'hDEADBEEF to 0x0000_0010, then read 0x10 after one IDLE
//    -> WE=4'hF at word 4; read returns 32'hDEADBEEF.
// 2. Byte write 8'hA5 (HSIZE=0) to 0x13 over a word holding 32'h11223344,
//    then read -> WE=4'b1000; read returns 32'hA5223344.
// 3. Back-to-back halfword write 16'hCAFE to 0x22, then immediate word read of
//    0x20 (RAM held 32'h0) -> HRDATA=32'hCAFE0000 via forwarding, no wait state.
// 4. Back-to-back write 0x30 then read 0x34 -> no forwarding;
//    read returns stored RAM word.
// 5. Write address phase with HREADY=0 (or HTRANS=IDLE), then HWDATA=32'hFFFF_FFFF
//    -> BRAM_WE stays 0; RAM unchanged.
// 6. Assert HRESETn low in the write data phase -> BRAM_WE=0 that cycle,
//    state=IDLE; a subsequent read shows old data.

Source files
------------

// File: rtl/ahblite_block_ram_ctrl.sv
// AHB-Lite slave front-end for a simple-dual-port block RAM.
// Reads are zero-wait: the address phase drives the RAM read port directly.
// Writes are captured in the address phase and committed in the data phase.
// A read of the word being written in the previous cycle is merged per byte lane.
module ahblite_block_ram_ctrl #(
  parameter int unsigned ADDR_WIDTH = 13
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [3:0]            HPROT,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic [31:0]           HRDATA,
  output logic [1:0]            HRESP,
  output logic [ADDR_WIDTH-1:0] BRAM_RDADDR,
  output logic [ADDR_WIDTH-1:0] BRAM_WRADDR,
  output logic [3:0]            BRAM_WE,
  output logic [31:0]           BRAM_WDATA,
  input  logic [31:0]           BRAM_RDATA
);

  typedef enum logic [1:0] {StIdle, StWr, StRd} state_e;

  state_e                  state_q, state_d;
  logic                    acc;
  logic                    hazard;
  logic [ADDR_WIDTH-1:0]   word_addr;
  logic [3:0]              addr_be;
  logic [ADDR_WIDTH-1:0]   wr_addr_q;
  logic [3:0]              wr_be_q;
  logic                    fwd_en_q;
  logic [3:0]              fwd_be_q;
  logic [31:0]             fwd_data_q;

  // HPROT and the address bits above the RAM region are intentionally ignored
  logic unused_bits;
  assign unused_bits = ^{HPROT, HADDR[31:ADDR_WIDTH+2]};

  assign acc       = HSEL & HTRANS[1] & HREADY;
  assign word_addr = HADDR[ADDR_WIDTH+1:2];

  // Byte-lane enables for the address-phase transfer; misaligned low bits ignored
  always_comb begin
    addr_be = 4'b1111;
    case (HSIZE)
      3'd0:    addr_be = 4'b0001 << HADDR[1:0];
      3'd1:    addr_be = HADDR[1] ? 4'b1100 : 4'b0011;
      default: addr_be = 4'b1111;
    endcase
  end

  // Data-phase ownership follows the accepted address phase every cycle
  always_comb begin
    state_d = StIdle;
    if (acc) begin
      state_d = HWRITE ? StWr : StRd;
    end
  end

  // Read of the word currently being committed must see the new bytes
  assign hazard = (state_q == StWr) && acc && !HWRITE && (word_addr == wr_addr_q);

  // Data-phase state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Write address-phase capture
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_addr_q <= '0;
      wr_be_q   <= 4'b0000;
    end else if (acc && HWRITE) begin
      wr_addr_q <= word_addr;
      wr_be_q   <= addr_be;
    end
  end

  // Forwarding registers for back-to-back write-then-read of the same word
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fwd_en_q   <= 1'b0;
      fwd_be_q   <= 4'b0000;
      fwd_data_q <= 32'h0;
    end else begin
      fwd_en_q <= hazard;
      if (hazard) begin
        fwd_be_q   <= wr_be_q;
        fwd_data_q <= HWDATA;
      end
    end
  end

  // RAM port drive and read-data merge
  always_comb begin
    BRAM_RDADDR = word_addr;
    BRAM_WRADDR = wr_addr_q;
    BRAM_WDATA  = HWDATA;
    BRAM_WE     = (state_q == StWr) ? wr_be_q : 4'b0000;
    HRDATA      = BRAM_RDATA;
    for (int n = 0; n < 4; n++) begin
      if ((state_q == StRd) && fwd_en_q && fwd_be_q[n]) begin
        HRDATA[8*n +: 8] = fwd_data_q[8*n +: 8];
      end
    end
  end

  assign HREADYOUT = 1'b1;
  assign HRESP     = 2'b00;

endmodule

// File: tb/tb_ahblite_block_ram_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor pops
// and compares in each data phase against a behavioural read-first RAM.
module tb_ahblite_block_ram_ctrl;

  localparam int unsigned AW = 13;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          HSEL = 1'b0;
  logic [31:0]   HADDR = 32'h0;
  logic [1:0]    HTRANS = 2'b00;
  logic [2:0]    HSIZE = 3'd2;
  logic [3:0]    HPROT = 4'h3;
  logic          HWRITE = 1'b0;
  logic [31:0]   HWDATA = 32'h0;
  logic          HREADY = 1'b1;
  logic          HREADYOUT;
  logic [31:0]   HRDATA;
  logic [1:0]    HRESP;
  logic [AW-1:0] BRAM_RDADDR;
  logic [AW-1:0] BRAM_WRADDR;
  logic [3:0]    BRAM_WE;
  logic [31:0]   BRAM_WDATA;
  logic [31:0]   BRAM_RDATA = 32'h0;

  ahblite_block_ram_ctrl #(.ADDR_WIDTH(AW)) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .HSEL        (HSEL),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HSIZE       (HSIZE),
    .HPROT       (HPROT),
    .HWRITE      (HWRITE),
    .HWDATA      (HWDATA),
    .HREADY      (HREADY),
    .HREADYOUT   (HREADYOUT),
    .HRDATA      (HRDATA),
    .HRESP       (HRESP),
    .BRAM_RDADDR (BRAM_RDADDR),
    .BRAM_WRADDR (BRAM_WRADDR),
    .BRAM_WE     (BRAM_WE),
    .BRAM_WDATA  (BRAM_WDATA),
    .BRAM_RDATA  (BRAM_RDATA)
  );

  always #5 HCLK = ~HCLK;

  // Behavioural RAM: synchronous read-first read port, byte-enabled write port
  logic [31:0] mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
  always @(posedge HCLK) begin
    BRAM_RDATA <= mem[BRAM_RDADDR];
    for (int n = 0; n < 4; n++) begin
      if (BRAM_WE[n]) mem[BRAM_WRADDR][8*n +: 8] <= BRAM_WDATA[8*n +: 8];
    end
  end

  typedef struct packed {
    logic [3:0]    be;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_exp_t;

  wr_exp_t     we_q [$];
  logic [31:0] rd_q [$];
  int          checks = 0;
  int          passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Bus-side view of which data phase is in progress
  logic wr_dp = 1'b0;
  logic rd_dp = 1'b0;
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_dp <= 1'b0;
      rd_dp <= 1'b0;
    end else begin
      wr_dp <= HSEL & HTRANS[1] & HREADY & HWRITE;
      rd_dp <= HSEL & HTRANS[1] & HREADY & ~HWRITE;
    end
  end

  // Monitor: compare DUT outputs mid-cycle against queued expectations
  wr_exp_t e;
  logic [31:0] r;
  always @(negedge HCLK) begin
    if (wr_dp) begin
      if (we_q.size() == 0) begin
        checks++;
        $display("FAIL wr_queue: got write data phase expected none at %0t", $time);
      end else begin
        e = we_q.pop_front();
        check("bram_we", {28'h0, BRAM_WE}, {28'h0, e.be});
        check("bram_wraddr", {19'h0, BRAM_WRADDR}, {19'h0, e.addr});
        check("bram_wdata", BRAM_WDATA, e.data);
      end
    end else begin
      check("bram_we_idle", {28'h0, BRAM_WE}, 32'h0);
    end
    if (rd_dp) begin
      if (rd_q.size() == 0) begin
        checks++;
        $display("FAIL rd_queue: got read data phase expected none at %0t", $time);
      end else begin
        r = rd_q.pop_front();
        check("hrdata", HRDATA, r);
      end
    end
  end

  logic          pend_wr = 1'b0;
  logic [3:0]    pend_be = 4'h0;
  logic [AW-1:0] pend_addr = '0;

  // One bus cycle: new address phase plus write data for the previous one
  task automatic beat(input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [31:0] addr, input logic [2:0] size, input logic rdy,
                      input logic [3:0] xbe, input logic [31:0] wdata,
                      input logic [31:0] xrd);
    HSEL = sel; HTRANS = trans; HWRITE = wr; HADDR = addr; HSIZE = size;
    HREADY = rdy; HWDATA = wdata;
    if (pend_wr) we_q.push_back({pend_be, pend_addr, wdata});
    pend_wr = 1'b0;
    if (sel && trans[1] && rdy) begin
      if (wr) begin
        pend_wr = 1'b1; pend_be = xbe; pend_addr = addr[AW+1:2];
      end else begin
        rd_q.push_back(xrd);
      end
    end
    @(posedge HCLK); #1;
  endtask

  task automatic idle(input logic [31:0] wdata);
    beat(1'b0, 2'b00, 1'b0, 32'h0, 3'd2, 1'b1, 4'h0, wdata, 32'h0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [2:0] size, input logic [3:0] xbe,
                    input logic [31:0] wdata);
    beat(1'b1, 2'b10, 1'b1, addr, size, 1'b1, xbe, wdata, 32'h0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] xrd);
    beat(1'b1, 2'b10, 1'b0, addr, 3'd2, 1'b1, 4'h0, wdata, xrd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge HCLK);
    #2;
    check("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
    check("rst_hresp", {30'h0, HRESP}, 32'h0);
    check("rst_we", {28'h0, BRAM_WE}, 32'h0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    idle(32'h0);

    // Word write then read after idles
    wr(32'h0000_0010, 3'd2, 4'hF, 32'h0);
    idle(32'hDEAD_BEEF);
    idle(32'h0);
    rd(32'h0000_0010, 32'h0, 32'hDEAD_BEEF);
    idle(32'h0);

    // Byte write into upper lane of a preloaded word
    wr(32'h0000_0040, 3'd2, 4'hF, 32'h0);
    idle(32'h1122_3344);
    wr(32'h0000_0043, 3'd0, 4'b1000, 32'h0);
    idle(32'hA5A5_A5A5);
    rd(32'h0000_0040, 32'h0, 32'hA522_3344);
    idle(32'h0);

    // Halfword write immediately followed by read of the same word
    wr(32'h0000_0022, 3'd1, 4'b1100, 32'h0);
    rd(32'h0000_0020, 32'hCAFE_CAFE, 32'hCAFE_0000);
    idle(32'h0);

    // Forwarding merge with RAM bytes that are non-zero
    wr(32'h0000_0050, 3'd2, 4'hF, 32'h0);
    idle(32'h1122_3344);
    wr(32'h0000_0051, 3'd0, 4'b0010, 32'h0);
    rd(32'h0000_0050, 32'h0000_7700, 32'h1122_7744);
    idle(32'h0);

    // Back-to-back write/read to different words: no forwarding
    wr(32'h0000_0034, 3'd2, 4'hF, 32'h0);
    idle(32'h5566_7788);
    wr(32'h0000_0030, 3'd2, 4'hF, 32'h0);
    rd(32'h0000_0034, 32'h9999_9999, 32'h5566_7788);
    rd(32'h0000_0030, 32'h0, 32'h9999_9999);
    idle(32'h0);

    // Write address phases that must not be accepted
    beat(1'b1, 2'b10, 1'b1, 32'h0000_0060, 3'd2, 1'b0, 4'hF, 32'h0, 32'h0);
    idle(32'hFFFF_FFFF);
    beat(1'b1, 2'b00, 1'b1, 32'h0000_0060, 3'd2, 1'b1, 4'hF, 32'h0, 32'h0);
    idle(32'hFFFF_FFFF);
    rd(32'h0000_0060, 32'h0, 32'h0000_0000);
    idle(32'h0);

    // Reset asserted during a write data phase drops the write
    wr(32'h0000_0010, 3'd2, 4'hF, 32'h0);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h1234_5678;
    pend_wr = 1'b0;
    #1 HRESETn = 1'b0;
    #1 check("we_reset_mid", {28'h0, BRAM_WE}, 32'h0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    idle(32'h0);
    rd(32'h0000_0010, 32'h0, 32'hDEAD_BEEF);
    idle(32'h0);
    idle(32'h0);

    check("wr_queue_empty", we_q.size(), 32'h0);
    check("rd_queue_empty", rd_q.size(), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
